// File: rtl/multi_channel_press_counter.sv
// N independent up/down press counters, each scanned onto its own 7-segment display.
// Pins are registered: 1 cycle from count/digit-index change; no backpressure, every pulse is taken.
module multi_channel_press_counter #(
   parameter     MODE         = "HEX",
   parameter int NUM_SEGMENTS = 4,
   parameter int NUM_CHANNELS = 2,
   parameter int CLK_PER      = 10,
   parameter int REFR_RATE    = 1000,
   parameter bit SATURATE     = 1'b0,
   parameter bit BLANK_LZ     = 1'b1
) (
   input  logic                                       clk,
   input  logic                                       CPU_RESETN,
   input  logic [NUM_CHANNELS-1:0]                    btn_up,
   input  logic [NUM_CHANNELS-1:0]                    btn_down,
   input  logic [NUM_CHANNELS-1:0]                    clear,
   output logic [NUM_CHANNELS-1:0]                    overflow,
   output logic [NUM_CHANNELS-1:0][NUM_SEGMENTS-1:0]  anode,
   output logic [NUM_CHANNELS-1:0][7:0]               cathode
);

   localparam bit     IS_DEC      = (MODE == "DEC");
   localparam int     W           = 4 * NUM_SEGMENTS;
   localparam longint SCAN_RAW    = 64'd1_000_000_000 /
                                    (longint'(CLK_PER) * longint'(REFR_RATE) * longint'(NUM_SEGMENTS));
   localparam int     SCAN_CYCLES = (SCAN_RAW < 1) ? 1 : int'(SCAN_RAW);
   localparam int     SW          = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int     IW          = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;
   localparam logic [W-1:0] MAXV  = IS_DEC ? {NUM_SEGMENTS{4'h9}} : {W{1'b1}};

   logic [NUM_CHANNELS-1:0][W-1:0]            count_q, count_d;
   logic [NUM_CHANNELS-1:0]                   up_q, dn_q, ovf_q, ovf_d;
   logic [SW-1:0]                             scan_q, scan_d;
   logic [IW-1:0]                             idx_q, idx_d;
   logic [NUM_CHANNELS-1:0][NUM_SEGMENTS-1:0] anode_q, anode_d;
   logic [NUM_CHANNELS-1:0][7:0]              cathode_q, cathode_d;

   // Step one unit in either binary or BCD (ripple carry/borrow across nibbles).
   function automatic logic [W-1:0] bump(input logic [W-1:0] v, input logic up);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      if (!IS_DEC) begin
         r = up ? v + W'(1) : v - W'(1);
      end else begin
         for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (c) begin
               if (up) begin
                  if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                  else begin r[4*i +: 4] = v[4*i +: 4] + 4'd1; c = 1'b0; end
               end else begin
                  if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                  else begin r[4*i +: 4] = v[4*i +: 4] - 4'd1; c = 1'b0; end
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
         4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
         4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
         4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
      endcase
   endfunction

   always_comb begin
      logic up_p, dn_p;
      count_d = count_q;
      ovf_d   = ovf_q;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         up_p = btn_up[ch]   & ~up_q[ch];
         dn_p = btn_down[ch] & ~dn_q[ch];
         if (clear[ch]) begin
            count_d[ch] = '0;
            ovf_d[ch]   = 1'b0;
         end else if (up_p && dn_p) begin
            count_d[ch] = count_q[ch];
         end else if (up_p) begin
            if (count_q[ch] == MAXV) begin
               ovf_d[ch]   = 1'b1;
               count_d[ch] = SATURATE ? MAXV : '0;
            end else begin
               count_d[ch] = bump(count_q[ch], 1'b1);
            end
         end else if (dn_p) begin
            if (count_q[ch] == '0) begin
               ovf_d[ch]   = 1'b1;
               count_d[ch] = SATURATE ? '0 : MAXV;
            end else begin
               count_d[ch] = bump(count_q[ch], 1'b0);
            end
         end
      end
   end

   always_comb begin
      scan_d = scan_q + SW'(1);
      idx_d  = idx_q;
      if (scan_q == SW'(SCAN_CYCLES - 1)) begin
         scan_d = '0;
         idx_d  = (idx_q == IW'(NUM_SEGMENTS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   // All channels share the digit index; a blanked digit keeps its anode driven.
   always_comb begin
      logic [7:0] seg;
      logic       blank;
      anode_d   = '1;
      cathode_d = '1;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         blank = BLANK_LZ && (idx_q != '0) && ((count_q[ch] >> (4 * idx_q)) == '0);
         seg   = blank ? 8'hFF : seg7(count_q[ch][4*idx_q +: 4]);
         if (ovf_q[ch] && (idx_q == IW'(NUM_SEGMENTS - 1))) seg[7] = 1'b0;
         anode_d[ch]   = ~(NUM_SEGMENTS'(1) << idx_q);
         cathode_d[ch] = seg;
      end
   end

   always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         count_q   <= '0;
         up_q      <= '0;
         dn_q      <= '0;
         ovf_q     <= '0;
         scan_q    <= '0;
         idx_q     <= '0;
         anode_q   <= '1;
         cathode_q <= '1;
      end else begin
         count_q   <= count_d;
         up_q      <= btn_up;
         dn_q      <= btn_down;
         ovf_q     <= ovf_d;
         scan_q    <= scan_d;
         idx_q     <= idx_d;
         anode_q   <= anode_d;
         cathode_q <= cathode_d;
      end
   end

   assign overflow = ovf_q;
   assign anode    = anode_q;
   assign cathode  = cathode_q;

endmodule

// File: tb/tb_multi_channel_press_counter.sv
// Directed bench: one HEX/wrap, one DEC/wrap and one DEC/saturate instance share the same buttons.
module tb_multi_channel_press_counter;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [1:0]      btn_up = '0, btn_down = '0, clear = '0;
   logic [1:0]      ov_h, ov_d0, ov_d1;
   logic [1:0][3:0] an_h, an_d0, an_d1;
   logic [1:0][7:0] ca_h, ca_d0, ca_d1;

   logic [7:0] cap_h  [2][4];
   logic [7:0] cap_d0 [2][4];
   logic [7:0] cap_d1 [2][4];
   logic [3:0] an_exp [4];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_channel_press_counter #(.MODE("HEX"), .NUM_SEGMENTS(4), .NUM_CHANNELS(2), .CLK_PER(125000),
      .REFR_RATE(1000), .SATURATE(1'b0), .BLANK_LZ(1'b1)) u_hex (
      .clk(clk), .CPU_RESETN(rst_n), .btn_up(btn_up), .btn_down(btn_down), .clear(clear),
      .overflow(ov_h), .anode(an_h), .cathode(ca_h));

   multi_channel_press_counter #(.MODE("DEC"), .NUM_SEGMENTS(4), .NUM_CHANNELS(2), .CLK_PER(125000),
      .REFR_RATE(1000), .SATURATE(1'b0), .BLANK_LZ(1'b1)) u_dec_wrap (
      .clk(clk), .CPU_RESETN(rst_n), .btn_up(btn_up), .btn_down(btn_down), .clear(clear),
      .overflow(ov_d0), .anode(an_d0), .cathode(ca_d0));

   multi_channel_press_counter #(.MODE("DEC"), .NUM_SEGMENTS(4), .NUM_CHANNELS(2), .CLK_PER(125000),
      .REFR_RATE(1000), .SATURATE(1'b1), .BLANK_LZ(1'b1)) u_dec_sat (
      .clk(clk), .CPU_RESETN(rst_n), .btn_up(btn_up), .btn_down(btn_down), .clear(clear),
      .overflow(ov_d1), .anode(an_d1), .cathode(ca_d1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic press_up(input int ch);
      btn_up[ch] = 1'b1; tick();
      btn_up[ch] = 1'b0; tick();
   endtask

   task automatic press_dn(input int ch);
      btn_down[ch] = 1'b1; tick();
      btn_down[ch] = 1'b0; tick();
   endtask

   task automatic do_clear(input int ch);
      clear[ch] = 1'b1; tick();
      clear[ch] = 1'b0; tick();
   endtask

   // Record, per instance/channel, the cathode seen while each anode bit is low.
   task automatic capture();
      for (int c = 0; c < 2; c++)
         for (int d = 0; d < 4; d++) begin
            cap_h[c][d] = 8'h00; cap_d0[c][d] = 8'h00; cap_d1[c][d] = 8'h00;
         end
      for (int k = 0; k < 8; k++) begin
         tick();
         for (int c = 0; c < 2; c++)
            for (int d = 0; d < 4; d++) begin
               if (!an_h[c][d])  cap_h[c][d]  = ca_h[c];
               if (!an_d0[c][d]) cap_d0[c][d] = ca_d0[c];
               if (!an_d1[c][d]) cap_d1[c][d] = ca_d1[c];
            end
      end
   endtask

   initial begin
      an_exp[0] = 4'hE; an_exp[1] = 4'hD; an_exp[2] = 4'hB; an_exp[3] = 4'h7;

      // Reset state and scan order
      #2 rst_n = 1'b0;
      tick(); tick();
      chk("rst_anode", an_h[0], 4'hF);
      chk("rst_cathode", ca_h[0], 8'hFF);
      chk("rst_ovf", ov_h, 2'b00);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("scan_anode_%0d", k), an_h[0], an_exp[k/2]);
         chk($sformatf("scan_cath_%0d", k), ca_h[0], (k < 2) ? 8'hC0 : 8'hFF);
      end

      // 0x12 / 18 up presses on ch0
      for (int i = 0; i < 18; i++) press_up(0);
      capture();
      chk("hex18_d0", cap_h[0][0], 8'hA4);
      chk("hex18_d1", cap_h[0][1], 8'hF9);
      chk("hex18_d2", cap_h[0][2], 8'hFF);
      chk("hex18_d3", cap_h[0][3], 8'hFF);
      chk("hex18_ch1", cap_h[1][0], 8'hC0);
      chk("dec18_d0", cap_d0[0][0], 8'h80);
      chk("dec18_d1", cap_d0[0][1], 8'hF9);
      chk("hex18_ovf", ov_h, 2'b00);
      do_clear(0);

      // Down from zero: wrap vs saturate
      press_dn(0);
      capture();
      chk("hexdn_d0", cap_h[0][0], 8'h8E);
      chk("hexdn_d3", cap_h[0][3], 8'h0E);
      chk("decwrap_d0", cap_d0[0][0], 8'h90);
      chk("decwrap_d3", cap_d0[0][3], 8'h10);
      chk("decwrap_ovf", ov_d0[0], 1'b1);
      chk("decsat_d0", cap_d1[0][0], 8'hC0);
      chk("decsat_d3", cap_d1[0][3], 8'h7F);
      chk("decsat_ovf", ov_d1[0], 1'b1);
      do_clear(0);
      chk("clr_ovf_hex", ov_h[0], 1'b0);
      chk("clr_ovf_dec", ov_d0[0], 1'b0);

      // Simultaneous up+down, then clear beating an up pulse
      btn_up[1] = 1'b1; btn_down[1] = 1'b1; tick();
      btn_up[1] = 1'b0; btn_down[1] = 1'b0; tick();
      capture();
      chk("updn_d0", cap_h[1][0], 8'hC0);
      chk("updn_ovf", ov_h[1], 1'b0);
      press_dn(1);
      chk("ch1dn_ovf", ov_h[1], 1'b1);
      clear[1] = 1'b1; btn_up[1] = 1'b1; tick();
      clear[1] = 1'b0; btn_up[1] = 1'b0; tick();
      capture();
      chk("clrup_d0", cap_h[1][0], 8'hC0);
      chk("clrup_d1", cap_h[1][1], 8'hFF);
      chk("clrup_ovf", ov_h[1], 1'b0);
      chk("clrup_ch0", cap_h[0][0], 8'hC0);

      // Held button counts once, including across a reset
      btn_up[0] = 1'b1;
      repeat (50) tick();
      capture();
      chk("hold_d0", cap_h[0][0], 8'hF9);
      chk("hold_d1", cap_h[0][1], 8'hFF);
      chk("hold_dec_d0", cap_d0[0][0], 8'hF9);
      rst_n = 1'b0;
      #1;
      chk("midrst_anode", an_h[0], 4'hF);
      chk("midrst_cath", ca_h[0], 8'hFF);
      tick();
      rst_n = 1'b1;
      tick();
      chk("rel_anode", an_h[0], 4'hE);
      chk("rel_cath", ca_h[0], 8'hC0);
      repeat (10) tick();
      capture();
      chk("rel_hold_d0", cap_h[0][0], 8'hF9);
      chk("rel_hold_d1", cap_h[0][1], 8'hFF);
      btn_up[0] = 1'b0; tick();
      do_clear(0);

      // 0xFFFF + up wraps to 0 with overflow, DP on the top digit only
      press_dn(0);
      press_up(0);
      capture();
      chk("wrap_d0", cap_h[0][0], 8'hC0);
      chk("wrap_d1", cap_h[0][1], 8'hFF);
      chk("wrap_d2", cap_h[0][2], 8'hFF);
      chk("wrap_d3", cap_h[0][3], 8'h7F);
      chk("wrap_ovf", ov_h[0], 1'b1);
      chk("decwrap2_d0", cap_d0[0][0], 8'hC0);
      chk("decwrap2_d3", cap_d0[0][3], 8'h7F);
      chk("decsat2_d0", cap_d1[0][0], 8'hF9);
      chk("decsat2_d3", cap_d1[0][3], 8'h7F);
      chk("wrap_ch1", cap_h[1][3], 8'hFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
